fetch_unit: RTL and testbench

Instruction fetch stage sitting directly downstream of the program counter. It uses the PC output as the instruction memory address and runs a read handshake with memory. It latches the returned byte into an instruction register, presents it to the decoder with a valid/ready handshake, and pulses the PC increment. Jumps are performed by driving the target onto the shared PC bus and pulsing the PC write strobe.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads the byte at the current PC, holds it for the decoder
// behind a valid/ready handshake, and performs jumps by loading the PC over the shared bus.
`timescale 1ns/1ps

module fetch_unit #(
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [7:0]  IR_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pc_addr,
    inout  wire  [7:0] pc_bus,
    output logic       pc_w,
    output logic       pc_i,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic [7:0] mem_data,
    input  logic       mem_ack,
    output logic [7:0] ir_out,
    output logic       ir_valid,
    input  logic       ir_ready,
    input  logic       jump_req,
    input  logic [7:0] jump_target,
    output logic       jump_ack,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        JUMP,
        SETTLE,
        FAULT
    } state_t;

    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] irOut_q, irOut_d;
    logic       irValid_q, irValid_d;
    logic [7:0] timeoutCnt_q, timeoutCnt_d;
    logic       pcIncStrobe;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            irOut_q      <= IR_RESET;
            irValid_q    <= 1'b0;
            timeoutCnt_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            irOut_q      <= irOut_d;
            irValid_q    <= irValid_d;
            timeoutCnt_q <= timeoutCnt_d;
        end
    end

    // The counter only survives REQ->REQ, so every entry into REQ starts it from zero.
    always_comb begin
        state_d      = state_q;
        irOut_d      = irOut_q;
        irValid_d    = irValid_q;
        timeoutCnt_d = 8'h00;
        pcIncStrobe  = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (mem_ack) begin
                    if (!jump_req) begin
                        irOut_d     = mem_data;
                        irValid_d   = 1'b1;
                        pcIncStrobe = 1'b1;
                        state_d     = HOLD;
                    end else begin
                        state_d = JUMP;
                    end
                end else if (({1'b0, timeoutCnt_q} + 9'd1) == TIMEOUT_LIMIT) begin
                    state_d = FAULT;
                end else begin
                    timeoutCnt_d = timeoutCnt_q + 8'd1;
                end
            end
            HOLD: begin
                // A pending jump discards the held instruction even if the decoder is ready.
                if (jump_req) begin
                    irValid_d = 1'b0;
                    state_d   = JUMP;
                end else if (ir_ready) begin
                    irValid_d = 1'b0;
                    state_d   = REQ;
                end
            end
            JUMP: begin
                irValid_d = 1'b0;
                state_d   = SETTLE;
            end
            SETTLE: state_d = REQ;
            FAULT:  irValid_d = 1'b0;
            default: state_d = IDLE;
        endcase
    end

    assign mem_rd   = (state_q == REQ);
    assign mem_addr = mem_rd ? pc_addr : 8'h00;
    assign pc_i     = pcIncStrobe & ~reset;
    assign pc_w     = (state_q == JUMP);
    assign jump_ack = (state_q == JUMP);
    assign fault    = (state_q == FAULT);
    assign ir_out   = irOut_q;
    assign ir_valid = irValid_q;
    assign pc_bus   = pc_w ? jump_target : 8'hZZ;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small PC register and scripted memory surround the DUT,
// and every cycle's expectations are written out by hand.
`timescale 1ns/1ps

module tb_fetch_unit;

    logic       clk;
    logic       reset;
    logic [7:0] pcModel;
    wire  [7:0] pc_bus;
    logic       pc_w, pc_i;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data;
    logic       mem_ack;
    logic [7:0] ir_out;
    logic       ir_valid;
    logic       ir_ready;
    logic       jump_req;
    logic [7:0] jump_target;
    logic       jump_ack;
    logic       fault;

    int checkCount = 0;
    int failCount  = 0;
    int pcIncCount = 0;
    int pcWrCount  = 0;
    int bothCount  = 0;
    int reqCycles  = 0;
    int ackDelay   = 1;
    bit memAuto    = 0;

    fetch_unit #(.TIMEOUT(15), .IR_RESET(8'h00)) dut (
        .clk(clk), .reset(reset), .pc_addr(pcModel), .pc_bus(pc_bus),
        .pc_w(pc_w), .pc_i(pc_i), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .mem_ack(mem_ack), .ir_out(ir_out),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .jump_req(jump_req),
        .jump_target(jump_target), .jump_ack(jump_ack), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program counter the fetch unit drives: loads from the bus, increments on pc_i.
    always @(posedge clk) begin
        if (reset)     pcModel <= 8'h00;
        else if (pc_w) pcModel <= pc_bus;
        else if (pc_i) pcModel <= pcModel + 8'd1;
    end

    always @(negedge clk) begin
        if (pc_i) pcIncCount += 1;
        if (pc_w) pcWrCount += 1;
        if (pc_i && pc_w) bothCount += 1;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one cycle; when enabled, the memory acks ackDelay cycles after mem_rd rises.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (memAuto) begin
            if (mem_rd) reqCycles++;
            else        reqCycles = 0;
            mem_ack  = mem_rd && (reqCycles == ackDelay + 1);
            mem_data = mem_addr + 8'h10;
        end
        #1;
    endtask

    initial begin
        int waited;
        int incStart;
        int wrStart;
        reset = 1; mem_ack = 0; mem_data = 0; ir_ready = 0;
        jump_req = 0; jump_target = 0;

        applyStimulus();
        checkOutput("rstIrOut", 32'(ir_out), 0);
        checkOutput("rstIrValid", 32'(ir_valid), 0);
        checkOutput("rstMemRd", 32'(mem_rd), 0);
        checkOutput("rstMemAddr", 32'(mem_addr), 0);
        checkOutput("rstPcW", 32'(pc_w), 0);
        checkOutput("rstPcI", 32'(pc_i), 0);
        checkOutput("rstJumpAck", 32'(jump_ack), 0);
        checkOutput("rstFault", 32'(fault), 0);

        reset = 0; memAuto = 1; ir_ready = 1;
        incStart = pcIncCount; wrStart = pcWrCount;
        for (int f = 0; f < 3; f++) begin
            waited = 0;
            while (!mem_rd && waited < 10) begin applyStimulus(); waited++; end
            checkOutput("seqRd", 32'(mem_rd), 1);
            checkOutput("seqAddr", 32'(mem_addr), 32'(f));
            waited = 0;
            while (!ir_valid && waited < 10) begin applyStimulus(); waited++; end
            checkOutput("seqValid", 32'(ir_valid), 1);
            checkOutput("seqIr", 32'(ir_out), 32'('h10 + f));
            if (f == 0) checkOutput("seqLatency", 32'(waited), 2);
        end
        checkOutput("seqPcIncs", 32'(pcIncCount - incStart), 3);
        checkOutput("seqPcWrites", 32'(pcWrCount - wrStart), 0);

        memAuto = 0; mem_ack = 0;
        applyStimulus();
        checkOutput("stallAddr", 32'(mem_addr), 'h03);
        mem_ack = 1; mem_data = 8'h3C;
        #1;
        checkOutput("stallPcI", 32'(pc_i), 1);
        applyStimulus();
        mem_ack = 0; ir_ready = 0;
        incStart = pcIncCount;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("stallValid", 32'(ir_valid), 1);
            checkOutput("stallIr", 32'(ir_out), 'h3C);
            checkOutput("stallMemRd", 32'(mem_rd), 0);
        end
        checkOutput("stallNoPcI", 32'(pcIncCount - incStart), 0);
        ir_ready = 1;
        applyStimulus();
        checkOutput("stallResumeRd", 32'(mem_rd), 1);
        checkOutput("stallResumeAddr", 32'(mem_addr), 'h04);

        mem_ack = 1; mem_data = 8'h55;
        applyStimulus();
        mem_ack = 0; jump_req = 1; jump_target = 8'hA5;
        wrStart = pcWrCount;
        applyStimulus();
        checkOutput("jholdPcW", 32'(pc_w), 1);
        checkOutput("jholdAck", 32'(jump_ack), 1);
        checkOutput("jholdBus", 32'(pc_bus), 'hA5);
        checkOutput("jholdValid", 32'(ir_valid), 0);
        checkOutput("jholdPcI", 32'(pc_i), 0);
        jump_req = 0;
        applyStimulus();
        checkOutput("settlePcW", 32'(pc_w), 0);
        checkOutput("settleAck", 32'(jump_ack), 0);
        checkOutput("settleMemRd", 32'(mem_rd), 0);
        applyStimulus();
        checkOutput("jholdNewAddr", 32'(mem_addr), 'hA5);
        checkOutput("jholdWrites", 32'(pcWrCount - wrStart), 1);

        incStart = pcIncCount;
        jump_req = 1; jump_target = 8'h40;
        applyStimulus();
        checkOutput("jreqStillRd", 32'(mem_rd), 1);
        applyStimulus();
        mem_ack = 1; mem_data = 8'h77;
        #1;
        checkOutput("jreqNoPcI", 32'(pc_i), 0);
        applyStimulus();
        mem_ack = 0;
        checkOutput("jreqAck", 32'(jump_ack), 1);
        checkOutput("jreqBus", 32'(pc_bus), 'h40);
        checkOutput("jreqIrKept", 32'(ir_out), 'h55);
        checkOutput("jreqValid", 32'(ir_valid), 0);
        jump_req = 0;
        applyStimulus();
        applyStimulus();
        checkOutput("jreqNewAddr", 32'(mem_addr), 'h40);
        checkOutput("jreqIncs", 32'(pcIncCount - incStart), 0);

        for (int i = 2; i <= 15; i++) applyStimulus();
        checkOutput("toLastReqRd", 32'(mem_rd), 1);
        checkOutput("toLastReqFault", 32'(fault), 0);
        applyStimulus();
        checkOutput("toFault", 32'(fault), 1);
        checkOutput("toMemRd", 32'(mem_rd), 0);
        checkOutput("toValid", 32'(ir_valid), 0);
        mem_ack = 1; jump_req = 1; jump_target = 8'h11;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("toSticky", 32'(fault), 1);
            checkOutput("toNoJump", 32'(jump_ack), 0);
        end
        jump_req = 0; mem_ack = 0; reset = 1;
        applyStimulus();
        checkOutput("toRstFault", 32'(fault), 0);
        checkOutput("toRstMemRd", 32'(mem_rd), 0);
        reset = 0;
        applyStimulus();
        checkOutput("toRestartRd", 32'(mem_rd), 1);
        checkOutput("toRestartAddr", 32'(mem_addr), 'h00);

        // Ack arriving in the very cycle the timeout would fire must still complete the fetch.
        for (int i = 2; i <= 15; i++) applyStimulus();
        mem_ack = 1; mem_data = 8'h99;
        applyStimulus();
        mem_ack = 0;
        checkOutput("ackAtLimitFault", 32'(fault), 0);
        checkOutput("ackAtLimitValid", 32'(ir_valid), 1);
        checkOutput("ackAtLimitIr", 32'(ir_out), 'h99);
        applyStimulus();
        checkOutput("ackAtLimitNext", 32'(mem_addr), 'h01);

        mem_ack = 1; mem_data = 8'hEE; reset = 1;
        applyStimulus();
        checkOutput("midRstIr", 32'(ir_out), 'h00);
        checkOutput("midRstValid", 32'(ir_valid), 0);
        checkOutput("midRstMemRd", 32'(mem_rd), 0);
        checkOutput("midRstAddr", 32'(mem_addr), 'h00);
        checkOutput("midRstPcI", 32'(pc_i), 0);
        checkOutput("midRstPcW", 32'(pc_w), 0);
        checkOutput("midRstFault", 32'(fault), 0);
        reset = 0; mem_ack = 0;
        applyStimulus();

        checkOutput("strobeExclusive", 32'(bothCount), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
